imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous memory between the pipeline's instruction-fetch port (IF) and its data-memory port (D, load/store).
- Sits between the pipeline datapath and the unified program/data RAM.
- Sequences each access (enable, latency wait, data capture) and returns a one-cycle acknowledge to the winning requester.
- Gives D priority, with a starvation guard so fetch always progresses.

Parameters:
- DATA_WIDTH, 32, width of memory words and all data ports.
- ADDR_WIDTH, 32, width of all address ports.
- MEM_LATENCY, 1, cycles from the mem_en sampling edge to valid mem_rdata; legal 1..7.
- MAX_D_STREAK, 4, consecutive contended D grants allowed before IF is forced to win; legal 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in that cycle.
- if_rdata  out  DATA_WIDTH  fetched word; registered, holds until the next if_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_ack  out  1  one-cycle pulse on completion.
- d_rdata  out  DATA_WIDTH  load word; registered, holds until the next load d_ack.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high whenever state != IDLE.
- grant_d  out  1  high while a D transaction is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs are 0, including if_rdata/d_rdata, mem_* and the streak counter.
  - Any in-flight access is abandoned: mem_en drops immediately and no ack is issued for it.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - Samples if_req and d_req combinationally in this cycle, called cycle 0.
  - If either is high: select a winner; latch its address, we and wdata into mem_addr, mem_we and mem_wdata; go to ACCESS.
- Arbitration when both requests are high:
  - D wins unless streak==MAX_D_STREAK; in that case IF wins.
  - streak increments, saturating, on each D grant made while if_req=1.
  - streak clears to 0 on any IF grant.
  - Uncontended D grants leave streak unchanged.
- ACCESS:
  - mem_en=1 only in the first ACCESS cycle (cycle 1); mem_we=mem_en & latched we.
  - mem_addr and mem_wdata are held constant for the whole ACCESS period.
  - IF transactions have d_we treated as 0.
- ACCESS duration, counted by a latency counter:
  - Read: MEM_LATENCY+1 cycles (cycles 1..1+MEM_LATENCY). mem_rdata is captured into the winner's rdata register at the edge ending the last ACCESS cycle.
  - Write: 1 cycle; no data is captured.
- RESP:
  - The winner's ack=1 for exactly this one cycle, then the state returns to IDLE.
  - Read ack is in cycle MEM_LATENCY+2; write ack is in cycle 2.
  - Throughput: one read per MEM_LATENCY+3 cycles, one write per 3 cycles.
- Requester rule:
  - After seeing ack, a requester either drops req or presents a new request with new address/data.
  - The following IDLE cycle treats any high req as a new transaction.
- Request changes:
  - Requests arriving during ACCESS or RESP are not sampled until IDLE.
  - A req withdrawn before IDLE is never granted.
- Ack exclusivity: if_ack and d_ack are never high in the same cycle.
- grant_d: set on entering ACCESS for a D winner, cleared on leaving RESP.
- No address decoding or byte enables; peripheral (GPIO/UART) decoding stays downstream on the D path.

Test Plan:
1. Single fetch, MEM_LATENCY=1:
   - Stimulus: if_req=1, if_addr=0x0040_0000; memory returns 0x0050_0093.
   - Required: mem_en pulses only in cycle 1 with mem_addr=0x0040_0000; if_ack in cycle 3 with if_rdata=0x0050_0093; busy=1 in cycles 1-3.
2. Simultaneous requests, streak=0:
   - Stimulus: d_req (load 0x1001_0000) and if_req raised in the same cycle.
   - Required: d_ack fires first, and the IF transaction is granted in the very next IDLE cycle; streak returns to 0 after that IF grant.
3. Starvation guard, MAX_D_STREAK=4:
   - Stimulus: if_req held high while d_req is re-raised after every d_ack.
   - Required: exactly 4 d_acks, then if_ack; the D request after that wins again.
4. Store, MEM_LATENCY=3:
   - Stimulus: d_we=1, d_addr=0x1001_0024, d_wdata=0x0000_00A5.
   - Required: mem_en=mem_we=1 in cycle 1 only; d_ack in cycle 2; d_rdata unchanged.
5. Load, MEM_LATENCY=3:
   - Stimulus: memory returns 0xDEAD_BEEF from cycle 4.
   - Required: d_ack in cycle 5 with d_rdata=0xDEAD_BEEF.
6. Reset mid-operation:
   - Stimulus: assert reset during cycle 2 of a MEM_LATENCY=3 read.
   - Required: all outputs 0 immediately; no ack after reset release; the next request completes with nominal latency.

Source files
------------

// File: rtl/imem_dmem_arbiter_if.sv
// Request/ack and memory bus shared between the pipeline, the arbiter and the unified RAM.
// slave is the arbiter's view; master is the environment's view (pipeline ports plus RAM).
interface imem_dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates a single-port synchronous RAM between instruction fetch and data load/store.
// D has priority; after MAX_D_STREAK contended D grants, a waiting fetch is forced through.
module imem_dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  imem_dmem_arbiter_if.slave     bus,
  output logic                   busy,
  output logic                   grant_d,
  output logic [1:0]             state_dbg,
  output logic [3:0]             streak_dbg
);

  // Handshake: a requester raises req with stable address/data and holds it until its
  // one-cycle ack; requests are sampled only in IDLE, and a req seen in IDLE is always new.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  logic [2:0]            lat_cnt;
  logic [3:0]            streak;
  logic                  win_d;
  logic                  lat_we;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  if_ack_q;
  logic                  d_ack_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  logic streak_full;
  logic pick_d;
  logic any_req;
  logic access_done;

  always_comb begin
    streak_full = (streak == 4'(MAX_D_STREAK));
    pick_d      = bus.d_req & ~(bus.if_req & streak_full);
    any_req     = bus.if_req | bus.d_req;
    access_done = lat_we | (lat_cnt == 3'(MEM_LATENCY));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      streak      <= '0;
      win_d       <= 1'b0;
      lat_we      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy        <= 1'b0;
      grant_d     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          if (any_req) begin
            state    <= ACCESS;
            busy     <= 1'b1;
            lat_cnt  <= '0;
            mem_en_q <= 1'b1;
            if (pick_d) begin
              win_d       <= 1'b1;
              grant_d     <= 1'b1;
              lat_we      <= bus.d_we;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
              // Only D grants that made a fetch wait count toward the streak.
              if (bus.if_req && !streak_full) streak <= streak + 4'd1;
            end else begin
              win_d       <= 1'b0;
              grant_d     <= 1'b0;
              lat_we      <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= '0;
              streak      <= '0;
            end
          end
        end

        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (access_done) begin
            state <= RESP;
            if (win_d) begin
              d_ack_q <= 1'b1;
              if (!lat_we) d_rdata_q <= bus.mem_rdata;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end

        RESP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          grant_d  <= 1'b0;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          grant_d  <= 1'b0;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign state_dbg     = state;
  assign streak_dbg    = streak;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench: instance A uses MEM_LATENCY=1, instance B uses MEM_LATENCY=3.
// Each instance talks to a small RAM model whose read data is valid only in cycle 1+latency.
module tb_imem_dmem_arbiter;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  imem_dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ia ();
  imem_dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ib ();

  logic       busy_a, grant_d_a, busy_b, grant_d_b;
  logic [1:0] state_a, state_b;
  logic [3:0] streak_a, streak_b;

  imem_dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1), .MAX_D_STREAK(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ia), .busy(busy_a), .grant_d(grant_d_a),
    .state_dbg(state_a), .streak_dbg(streak_a)
  );

  imem_dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(3), .MAX_D_STREAK(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ib), .busy(busy_b), .grant_d(grant_d_b),
    .state_dbg(state_b), .streak_dbg(streak_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models
  logic [31:0] mem_a [logic [31:0]];
  logic [31:0] mem_b [logic [31:0]];
  logic [31:0] pipe_a = JUNK;
  logic [31:0] pipe_b [3] = '{JUNK, JUNK, JUNK};

  function automatic logic [31:0] rd_a(input logic [31:0] a);
    return mem_a.exists(a) ? mem_a[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_b(input logic [31:0] a);
    return mem_b.exists(a) ? mem_b[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (ia.mem_en && ia.mem_we) mem_a[ia.mem_addr] = ia.mem_wdata;
    pipe_a <= (ia.mem_en && !ia.mem_we) ? rd_a(ia.mem_addr) : JUNK;
  end

  always @(posedge clk) begin
    if (ib.mem_en && ib.mem_we) mem_b[ib.mem_addr] = ib.mem_wdata;
    pipe_b[0] <= (ib.mem_en && !ib.mem_we) ? rd_b(ib.mem_addr) : JUNK;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign ia.mem_rdata = pipe_a;
  assign ib.mem_rdata = pipe_b[2];

  // Scoreboard
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Acks from one arbiter must never coincide.
  always @(negedge clk) begin
    if (reset) begin
      check("ack_excl_a", {31'd0, ia.if_ack & ia.d_ack}, 32'd0);
      check("ack_excl_b", {31'd0, ib.if_ack & ib.d_ack}, 32'd0);
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    ia.if_req = 0; ia.if_addr = 0; ia.d_req = 0; ia.d_we = 0; ia.d_addr = 0; ia.d_wdata = 0;
    ib.if_req = 0; ib.if_addr = 0; ib.d_req = 0; ib.d_we = 0; ib.d_addr = 0; ib.d_wdata = 0;
  endtask

  task automatic drive_d_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    ib.d_req = 1; ib.d_we = we; ib.d_addr = addr; ib.d_wdata = wdata;
  endtask

  task automatic wait_d_ack_b(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ib.d_ack && cyc < 20);
  endtask

  int n_d;
  int n_ack;
  int cyc;
  logic got_if, after_if_d, done;

  initial begin
    reset = 1'b0;
    idle_inputs();
    mem_a[32'h0040_0000] = 32'h0050_0093;
    mem_a[32'h0040_0004] = 32'h0000_0013;
    mem_a[32'h1001_0000] = 32'h1111_2222;
    mem_b[32'h1001_0040] = 32'hDEAD_BEEF;
    mem_b[32'h1001_0080] = 32'h1234_5678;
    mem_b[32'h1001_0084] = 32'hCAFE_F00D;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state_a", state_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_mem_en_a", ia.mem_en, 0);
    check("rst_if_rdata_a", ia.if_rdata, 0);
    check("rst_streak_a", streak_a, 0);
    check("rst_d_rdata_b", ib.d_rdata, 0);
    check("rst_mem_addr_b", ib.mem_addr, 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: single fetch, latency 1
    ia.if_req = 1; ia.if_addr = 32'h0040_0000;
    @(negedge clk);
    check("t1_c1_mem_en", ia.mem_en, 1);
    check("t1_c1_mem_we", ia.mem_we, 0);
    check("t1_c1_mem_addr", ia.mem_addr, 32'h0040_0000);
    check("t1_c1_busy", busy_a, 1);
    @(negedge clk);
    check("t1_c2_mem_en", ia.mem_en, 0);
    check("t1_c2_if_ack", ia.if_ack, 0);
    check("t1_c2_busy", busy_a, 1);
    @(negedge clk);
    check("t1_c3_if_ack", ia.if_ack, 1);
    check("t1_c3_if_rdata", ia.if_rdata, 32'h0050_0093);
    check("t1_c3_busy", busy_a, 1);
    check("t1_c3_d_ack", ia.d_ack, 0);
    ia.if_req = 0;
    @(negedge clk);
    check("t1_c4_if_ack", ia.if_ack, 0);
    check("t1_c4_busy", busy_a, 0);
    check("t1_c4_if_rdata_hold", ia.if_rdata, 32'h0050_0093);

    // 2: simultaneous requests, D wins first, IF next
    ia.d_req = 1; ia.d_we = 0; ia.d_addr = 32'h1001_0000;
    ia.if_req = 1; ia.if_addr = 32'h0040_0004;
    @(negedge clk);
    check("t2_c1_mem_addr", ia.mem_addr, 32'h1001_0000);
    check("t2_c1_grant_d", grant_d_a, 1);
    check("t2_c1_streak", streak_a, 1);
    @(negedge clk);
    @(negedge clk);
    check("t2_c3_d_ack", ia.d_ack, 1);
    check("t2_c3_if_ack", ia.if_ack, 0);
    check("t2_c3_d_rdata", ia.d_rdata, 32'h1111_2222);
    ia.d_req = 0;
    @(negedge clk);
    check("t2_c4_idle", state_a, 0);
    check("t2_c4_grant_d", grant_d_a, 0);
    @(negedge clk);
    check("t2_c5_mem_en", ia.mem_en, 1);
    check("t2_c5_mem_addr", ia.mem_addr, 32'h0040_0004);
    check("t2_c5_grant_d", grant_d_a, 0);
    check("t2_c5_streak", streak_a, 0);
    @(negedge clk);
    @(negedge clk);
    check("t2_c7_if_ack", ia.if_ack, 1);
    check("t2_c7_if_rdata", ia.if_rdata, 32'h0000_0013);

    // 3: starvation guard -- both requesters keep re-requesting
    ia.if_addr = 32'h0040_0008;
    ia.d_req = 1; ia.d_we = 0; ia.d_addr = 32'h1001_0100;
    n_d = 0; got_if = 0; after_if_d = 0; done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (ia.d_ack) begin
        if (got_if) begin
          after_if_d = 1;
          done = 1;
        end else begin
          n_d++;
        end
        ia.d_addr = ia.d_addr + 32'd4;
      end
      if (ia.if_ack) begin
        if (got_if) done = 1;
        got_if = 1;
        ia.if_addr = ia.if_addr + 32'd4;
      end
    end
    check("t3_d_acks_before_if", n_d, 4);
    check("t3_if_ack_seen", {31'd0, got_if}, 1);
    check("t3_d_wins_after_if", {31'd0, after_if_d}, 1);
    ia.d_req = 0; ia.if_req = 0;
    @(negedge clk);
    check("t3_idle_after", busy_a, 0);

    // 4: store, latency 3
    drive_d_b(1'b1, 32'h1001_0024, 32'h0000_00A5);
    @(negedge clk);
    check("t4_c1_mem_en", ib.mem_en, 1);
    check("t4_c1_mem_we", ib.mem_we, 1);
    check("t4_c1_mem_addr", ib.mem_addr, 32'h1001_0024);
    check("t4_c1_mem_wdata", ib.mem_wdata, 32'h0000_00A5);
    check("t4_c1_grant_d", grant_d_b, 1);
    @(negedge clk);
    check("t4_c2_d_ack", ib.d_ack, 1);
    check("t4_c2_mem_en", ib.mem_en, 0);
    check("t4_c2_mem_we", ib.mem_we, 0);
    check("t4_c2_d_rdata", ib.d_rdata, 0);
    ib.d_req = 0;
    @(negedge clk);
    check("t4_c3_d_ack", ib.d_ack, 0);
    check("t4_c3_busy", busy_b, 0);
    check("t4_mem_written", rd_b(32'h1001_0024), 32'h0000_00A5);

    // 5: load, latency 3
    drive_d_b(1'b0, 32'h1001_0040, 32'h0);
    @(negedge clk);
    check("t5_c1_mem_en", ib.mem_en, 1);
    check("t5_c1_mem_we", ib.mem_we, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_c4_d_ack", ib.d_ack, 0);
    check("t5_c4_busy", busy_b, 1);
    @(negedge clk);
    check("t5_c5_d_ack", ib.d_ack, 1);
    check("t5_c5_d_rdata", ib.d_rdata, 32'hDEAD_BEEF);
    ib.d_req = 0;
    @(negedge clk);

    // 5b: read back the stored word
    exp_q.push_back(32'h0000_00A5);
    drive_d_b(1'b0, 32'h1001_0024, 32'h0);
    wait_d_ack_b(cyc);
    check("t5b_ack_cycle", cyc, 5);
    check("t5b_d_rdata", ib.d_rdata, exp_q.pop_front());
    ib.d_req = 0;
    @(negedge clk);

    // 6: reset during cycle 2 of a latency-3 read
    drive_d_b(1'b0, 32'h1001_0080, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_before", busy_b, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_busy", busy_b, 0);
    check("t6_rst_state", state_b, 0);
    check("t6_rst_grant_d", grant_d_b, 0);
    check("t6_rst_mem_addr", ib.mem_addr, 0);
    check("t6_rst_mem_en", ib.mem_en, 0);
    check("t6_rst_d_rdata", ib.d_rdata, 0);
    check("t6_rst_if_rdata_a", ia.if_rdata, 0);
    ib.d_req = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ib.d_ack) n_ack++;
    end
    check("t6_no_stale_ack", n_ack, 0);
    check("t6_d_rdata_after", ib.d_rdata, 0);
    exp_q.push_back(32'hCAFE_F00D);
    drive_d_b(1'b0, 32'h1001_0084, 32'h0);
    wait_d_ack_b(cyc);
    check("t6_next_ack_cycle", cyc, 5);
    check("t6_next_d_rdata", ib.d_rdata, exp_q.pop_front());
    ib.d_req = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
